// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : mul_div_unit
// Brief   : Multi-cycle HI/LO multiply/divide unit; MADD/MSUB need MDU_MADD_EN.
// Revision: 1.0 - initial release
// ============================================================================
module mul_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_RUN  = 1'b1;

  localparam logic [3:0] c_OP_MULT  = 4'b0000;
  localparam logic [3:0] c_OP_MULTU = 4'b0001;
  localparam logic [3:0] c_OP_DIV   = 4'b0010;
  localparam logic [3:0] c_OP_DIVU  = 4'b0011;
  localparam logic [3:0] c_OP_MTHI  = 4'b0100;
  localparam logic [3:0] c_OP_MTLO  = 4'b0101;
`ifdef MDU_MADD_EN
  localparam logic [3:0] c_OP_MADD  = 4'b0110;
  localparam logic [3:0] c_OP_MADDU = 4'b0111;
  localparam logic [3:0] c_OP_MSUB  = 4'b1000;
  localparam logic [3:0] c_OP_MSUBU = 4'b1001;
`endif

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic             w_inMult;
  logic             w_inDiv;
  logic             w_inMulti;
  logic [2*WIDTH-1:0] w_prodS;
  logic [2*WIDTH-1:0] w_prodU;
  logic             w_divSigned;
  logic [WIDTH-1:0] w_aMag;
  logic [WIDTH-1:0] w_bMag;
  logic [WIDTH-1:0] w_qMag;
  logic [WIDTH-1:0] w_rMag;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_resHi;
  logic [WIDTH-1:0] w_resLo;

  assign w_inMult = (op == c_OP_MULT) || (op == c_OP_MULTU);
  assign w_inDiv  = (op == c_OP_DIV)  || (op == c_OP_DIVU);
`ifdef MDU_MADD_EN
  assign w_inMulti = w_inMult || w_inDiv ||
                     (op == c_OP_MADD) || (op == c_OP_MADDU) ||
                     (op == c_OP_MSUB) || (op == c_OP_MSUBU);
`else
  assign w_inMulti = w_inMult || w_inDiv;
`endif

  // Sign-extending to 2*WIDTH lets a plain modular multiply yield the signed product.
  assign w_prodS = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_prodU = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

  // Magnitude division; MIN/-1 falls out correctly as the negated quotient wraps back.
  assign w_divSigned = (r_op == c_OP_DIV);
  assign w_aMag = (w_divSigned && r_a[WIDTH-1]) ? (~r_a + 1'b1) : r_a;
  assign w_bMag = (w_divSigned && r_b[WIDTH-1]) ? (~r_b + 1'b1) : r_b;
  assign w_qMag = (w_bMag == '0) ? '0 : (w_aMag / w_bMag);
  assign w_rMag = (w_bMag == '0) ? '0 : (w_aMag % w_bMag);
  assign w_quot = (w_divSigned && (r_a[WIDTH-1] ^ r_b[WIDTH-1])) ? (~w_qMag + 1'b1) : w_qMag;
  assign w_rem  = (w_divSigned && r_a[WIDTH-1]) ? (~w_rMag + 1'b1) : w_rMag;

  always_comb begin
    w_resHi = r_hi;
    w_resLo = r_lo;
    case (r_op)
      c_OP_MULT:  {w_resHi, w_resLo} = w_prodS;
      c_OP_MULTU: {w_resHi, w_resLo} = w_prodU;
      c_OP_DIV, c_OP_DIVU: begin
        if (r_b == '0) begin
          w_resHi = r_a;
          w_resLo = '1;
        end else begin
          w_resHi = w_rem;
          w_resLo = w_quot;
        end
      end
`ifdef MDU_MADD_EN
      c_OP_MADD:  {w_resHi, w_resLo} = {r_hi, r_lo} + w_prodS;
      c_OP_MADDU: {w_resHi, w_resLo} = {r_hi, r_lo} + w_prodU;
      c_OP_MSUB:  {w_resHi, w_resLo} = {r_hi, r_lo} - w_prodS;
      c_OP_MSUBU: {w_resHi, w_resLo} = {r_hi, r_lo} - w_prodU;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
      r_count <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            if (w_inMulti) begin
              r_state <= c_RUN;
              r_op    <= op;
              r_a     <= inA;
              r_b     <= inB;
              r_count <= w_inDiv ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
            end else if (op == c_OP_MTHI) begin
              r_hi <= inA;
            end else if (op == c_OP_MTLO) begin
              r_lo <= inA;
            end
          end
        end
        c_RUN: begin
          if (r_count == '0) begin
            r_state <= c_IDLE;
            r_hi    <= w_resHi;
            r_lo    <= w_resLo;
            r_done  <= 1'b1;
          end else begin
            r_count <= r_count - CNT_W'(1);
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign busy = (r_state == c_RUN);
  assign done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mul_div_unit
// Brief   : Scoreboard bench for mul_div_unit; MADDU vector follows MDU_MADD_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic         start   = 1'b0;
  logic [3:0]   op      = 4'h0;
  logic [W-1:0] inA     = '0;
  logic [W-1:0] inB     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  int nChecks = 0;
  int nFails  = 0;
  logic [2*W-1:0] expQ[$];

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .inA(inA), .inB(inB), .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL spurious_done: done=1 with HI/LO=%h, expected no completion", {HI, LO});
      end else begin
        check("result_hilo", {HI, LO}, expQ.pop_front());
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    inA   = a;
    inB   = b;
  endtask

  // Called right after issue(); returns at the negedge where done is seen.
  task automatic runToDone(input string name, input int expBusy, input int intrudeK);
    int  nb   = 0;
    bit  seen = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      start = (k == intrudeK);
      if (k == intrudeK) begin
        op  = 4'b0010;
        inA = 32'd100;
        inB = 32'd3;
      end else begin
        inA = $urandom;
        inB = $urandom;
      end
      if (busy) nb++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      nChecks++;
      nFails++;
      $display("FAIL %s_timeout: no done within 60 cycles, expected done", name);
    end
    check({name, "_busy_cycles"}, 64'(nb), 64'(expBusy));
  endtask

  task automatic singleOp(input logic [3:0] o, input logic [W-1:0] a);
    issue(o, a, '0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_hi", 64'(HI), 64'd0);
    check("reset_lo", 64'(LO), 64'd0);
    check("reset_busy_done", 64'({busy, done}), 64'd0);

    // Reset wins over a simultaneous MTHI
    singleOp(4'b0100, 32'hDEADBEEF);
    check("reset_priority_hi", 64'(HI), 64'd0);
    reset_n = 1'b1;

    issue(4'b0000, 32'hFFFFFFFF, 32'd2);
    expQ.push_back(64'hFFFFFFFF_FFFFFFFE);
    runToDone("mult", 5, 0);

    issue(4'b0010, 32'hFFFFFFF9, 32'd2);
    expQ.push_back(64'hFFFFFFFF_FFFFFFFD);
    runToDone("div", 10, 0);

    issue(4'b0011, 32'hFFFFFFF9, 32'd2);
    expQ.push_back(64'h00000001_7FFFFFFC);
    runToDone("divu", 10, 0);

    issue(4'b0011, 32'h00001234, 32'd0);
    expQ.push_back(64'h00001234_FFFFFFFF);
    runToDone("divu_by_zero", 10, 0);

    issue(4'b0010, 32'h80000000, 32'hFFFFFFFF);
    expQ.push_back(64'h00000000_80000000);
    runToDone("div_overflow", 10, 0);

    // Intruding DIV at T+2 must be ignored
    issue(4'b0001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    expQ.push_back(64'hFFFFFFFE_00000001);
    runToDone("multu_intrude", 5, 2);

    // Issued in the done cycle of the previous op
    issue(4'b0000, 32'd3, 32'hFFFFFFFC);
    expQ.push_back(64'hFFFFFFFF_FFFFFFF4);
    runToDone("mult_back_to_back", 5, 0);

    singleOp(4'b0100, 32'hA5A5A5A5);
    check("mthi_hi", 64'(HI), 64'h00000000_A5A5A5A5);
    check("mthi_busy_done", 64'({busy, done}), 64'd0);

    singleOp(4'b0101, 32'h5A5A5A5A);
    check("mtlo_lo", 64'(LO), 64'h00000000_5A5A5A5A);

    singleOp(4'b1111, 32'h12345678);
    check("undef_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    check("undef_hilo", {HI, LO}, 64'hA5A5A5A5_5A5A5A5A);

    singleOp(4'b0100, 32'h00000000);
    singleOp(4'b0101, 32'hFFFFFFFF);
    issue(4'b0111, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    expQ.push_back(64'h00000001_00000000);
    runToDone("maddu", 5, 0);
`else
    begin
      int nb = 0;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (busy) nb++;
      end
      check("maddu_disabled_busy", 64'(nb), 64'd0);
      check("maddu_disabled_hilo", {HI, LO}, 64'h00000000_FFFFFFFF);
    end
`endif

    // Reset at T+3 of a DIV aborts it without a done pulse
    @(negedge clk);
    issue(4'b0010, 32'd100, 32'd7);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("abort_hilo", {HI, LO}, 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (15) @(negedge clk);
    check("pending_results", 64'(expQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
